// File: rtl/in_channel.sv
// Host-to-machine input channel: a word FIFO filled by a valid/ready host port and drained
// by single-cycle "in" read requests that stall in a wait state while the buffer is empty.
module in_channel #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NIn                = 16
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          inValid,
  input  logic [MemoryElementWidth-1:0] inData,
  output logic                          inReady,
  input  logic                          rdReq,
  output logic                          rdAck,
  output logic [MemoryElementWidth-1:0] rdData,
  output logic                          rdWaiting,
  output logic [$clog2(NIn):0]          inSize,
  input  logic                          clear
);

  localparam int unsigned PtrW = $clog2(NIn);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(NIn);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                        r_state;
  logic [PtrW-1:0]               r_wr_ptr;
  logic [PtrW-1:0]               r_rd_ptr;
  logic [PtrW:0]                 r_size;
  logic                          r_ack;
  logic [MemoryElementWidth-1:0] r_data;
  logic [MemoryElementWidth-1:0] r_mem [NIn];

  logic w_empty;
  logic w_req;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_size == '0);
  assign inReady = resetN && !clear && (r_size < Full);
  assign w_push  = inValid && inReady;
  // A request is only honoured in IDLE and never in the cycle its predecessor is acked.
  assign w_req   = rdReq && !r_ack && (r_state == StIdle);
  assign w_pop   = resetN && !clear && !w_empty && ((r_state == StWait) || w_req);

  assign rdAck     = r_ack;
  assign rdData    = r_data;
  assign rdWaiting = (r_state == StWait);
  assign inSize    = r_size;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= inData;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state  <= StIdle;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_size   <= '0;
      r_ack    <= 1'b0;
      r_data   <= '0;
    end else if (clear) begin
      r_state  <= StIdle;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_size   <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_size <= r_size + 1'b1;
        2'b01:   r_size <= r_size - 1'b1;
        default: r_size <= r_size;
      endcase
      case (r_state)
        StIdle: if (w_req && w_empty) r_state <= StWait;
        StWait: if (w_pop) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_in_channel.sv
// Bench for in_channel: a per-cycle reference queue predicts acks, data, wait and size,
// backed by a constant vector table and hand-checked corner sequences.
module tb_in_channel;
  localparam int unsigned W = 12;
  localparam int unsigned N = 16;

  logic         clock = 1'b0;
  logic         resetN;
  logic         inValid;
  logic [W-1:0] inData;
  logic         inReady;
  logic         rdReq;
  logic         rdAck;
  logic [W-1:0] rdData;
  logic         rdWaiting;
  logic [4:0]   inSize;
  logic         clear;

  in_channel #(.MemoryElementWidth(W), .NIn(N)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .inValid   (inValid),
    .inData    (inData),
    .inReady   (inReady),
    .rdReq     (rdReq),
    .rdAck     (rdAck),
    .rdData    (rdData),
    .rdWaiting (rdWaiting),
    .inSize    (inSize),
    .clear     (clear)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: q holds accepted words in arrival order.
  logic [W-1:0] q[$];
  logic         m_ack  = 1'b0;
  logic         m_wait = 1'b0;
  logic [W-1:0] m_data = '0;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         rq;
    logic         ack;
    logic [W-1:0] data;
    int           size;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, predict the edge, compare at the following negedge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic rq, input logic clr,
                     input logic rstn);
    logic exp_ready;
    logic push;
    logic pop;
    logic nwait;
    inValid = v;
    inData  = d;
    rdReq   = rq;
    clear   = clr;
    resetN  = rstn;
    #1;
    exp_ready = rstn && !clr && (q.size() < N);
    chk("inReady", inReady, exp_ready);
    push = v && exp_ready;
    pop  = rstn && !clr && (q.size() > 0) && (m_wait || (rq && !m_ack));
    if (!rstn || clr) nwait = 1'b0;
    else if (m_wait)  nwait = (q.size() == 0);
    else              nwait = rq && !m_ack && (q.size() == 0);
    if (!rstn)    m_data = '0;
    else if (pop) m_data = q[0];
    m_ack  = pop;
    m_wait = nwait;
    if (!rstn || clr) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    @(posedge clock);
    @(negedge clock);
    chk("rdAck", rdAck, m_ack);
    chk("rdData", rdData, m_data);
    chk("rdWaiting", rdWaiting, m_wait);
    chk("inSize", inSize, q.size());
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [W-1:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd();
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] rnd;
    // Push 5,7,9 then three requests two cycles apart.
    tbl[0] = '{1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 1};
    tbl[1] = '{1'b1, 12'd7, 1'b0, 1'b0, 12'd0, 2};
    tbl[2] = '{1'b1, 12'd9, 1'b0, 1'b0, 12'd0, 3};
    tbl[3] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd5, 2};
    tbl[4] = '{1'b0, 12'd0, 1'b0, 1'b0, 12'd5, 2};
    tbl[5] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd7, 1};
    tbl[6] = '{1'b0, 12'd0, 1'b0, 1'b0, 12'd7, 1};
    tbl[7] = '{1'b0, 12'd0, 1'b1, 1'b1, 12'd9, 0};
    tbl[8] = '{1'b0, 12'd0, 1'b0, 1'b0, 12'd9, 0};

    cyc(1'b1, 12'd77, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset ack", rdAck, 0);
    chk("reset data", rdData, 0);
    chk("reset size", inSize, 0);
    chk("reset wait", rdWaiting, 0);

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].rq, 1'b0, 1'b1);
      chk($sformatf("tbl%0d.ack", i), rdAck, tbl[i].ack);
      chk($sformatf("tbl%0d.data", i), rdData, tbl[i].data);
      chk($sformatf("tbl%0d.size", i), inSize, tbl[i].size);
    end

    // Read on empty, word arrives three cycles later.
    rd();
    chk("wait set", rdWaiting, 1);
    idle();
    idle();
    push(12'h02A);
    chk("wait no bypass", rdAck, 0);
    idle();
    chk("wait ack", rdAck, 1);
    chk("wait data", rdData, 12'h02A);
    chk("wait clr", rdWaiting, 0);
    idle();

    // Fill to full with pointer wrap, try one more, drain.
    for (int i = 0; i < 16; i++) push(W'(i));
    chk("full size", inSize, 16);
    chk("full ready", inReady, 0);
    push(12'd99);
    chk("full size after extra", inSize, 16);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk($sformatf("drain%0d", i), rdData, i);
      idle();
    end
    chk("drained size", inSize, 0);

    // Same-edge push and pop with one word buffered.
    push(12'd40);
    cyc(1'b1, 12'd3, 1'b1, 1'b0, 1'b1);
    chk("pp ack", rdAck, 1);
    chk("pp data", rdData, 40);
    chk("pp size", inSize, 1);
    idle();
    rd();
    chk("pp next", rdData, 3);
    idle();

    // Clear while waiting abandons the read.
    rd();
    cyc(1'b1, 12'd55, 1'b1, 1'b1, 1'b1);
    chk("clr wait", rdWaiting, 0);
    chk("clr size", inSize, 0);
    push(12'd7);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("clr no ack", rdAck, 0);
    end
    rd();
    chk("clr later data", rdData, 7);
    idle();

    // Same with reset.
    rd();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst wait", rdWaiting, 0);
    chk("rst size", inSize, 0);
    chk("rst data", rdData, 0);
    push(12'd8);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst no ack", rdAck, 0);
    end
    rd();
    chk("rst later data", rdData, 8);
    idle();

    // Random mix against the reference queue.
    for (int k = 0; k < 2000; k++) begin
      rnd = W'($urandom);
      cyc((k < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0), rnd,
          $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
